// File: rtl/l1d_mshr_scheduler.sv
// L1D miss-status controller: allocates/merges MSHRs, issues line fills round-robin, replays merged tags in order.
// Optional `define MSHR_STATS_EN adds saturating primary/merge/stall counters.
module l1d_mshr_scheduler #(
    parameter int PADDR_BITS = 22,
    parameter int B          = 64,
    parameter int MSHR_COUNT = 4,
    parameter int MAX_MERGE  = 4,
    parameter int TAG_BITS   = 10
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  miss_valid_in,
    output logic                  miss_ready_out,
    input  logic [PADDR_BITS-1:0] miss_addr_in,
    input  logic [TAG_BITS-1:0]   miss_tag_in,
    input  logic                  miss_we_in,
    output logic                  lc_valid_out,
    input  logic                  lc_ready_in,
    output logic [PADDR_BITS-1:0] lc_addr_out,
    input  logic                  fill_valid_in,
    output logic                  fill_ready_out,
    input  logic [PADDR_BITS-1:0] fill_addr_in,
    output logic                  replay_valid_out,
    input  logic                  replay_ready_in,
    output logic [TAG_BITS-1:0]   replay_tag_out,
    output logic                  replay_we_out,
    output logic [PADDR_BITS-1:0] replay_addr_out,
    output logic                  unexpected_fill_out,
    output logic                  busy_out
`ifdef MSHR_STATS_EN
    ,
    output logic [31:0]           stat_primary_out,
    output logic [31:0]           stat_merge_out,
    output logic [31:0]           stat_stall_out
`endif
);
    localparam int OFF_BITS  = $clog2(B);
    localparam int LINE_BITS = PADDR_BITS - OFF_BITS;
    localparam int IDX_W     = (MSHR_COUNT > 1) ? $clog2(MSHR_COUNT) : 1;
    localparam int MP_W      = (MAX_MERGE > 1) ? $clog2(MAX_MERGE) : 1;
    localparam int CNT_W     = $clog2(MAX_MERGE + 1);

    typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_ISSUED, ST_REPLAY} st_e;

    st_e                  state_q [MSHR_COUNT];
    st_e                  state_d [MSHR_COUNT];
    logic [LINE_BITS-1:0] line_q  [MSHR_COUNT];
    logic [LINE_BITS-1:0] line_d  [MSHR_COUNT];
    logic [CNT_W-1:0]     cnt_q   [MSHR_COUNT];
    logic [CNT_W-1:0]     cnt_d   [MSHR_COUNT];
    logic [TAG_BITS-1:0]  tag_q   [MSHR_COUNT][MAX_MERGE];
    logic [TAG_BITS-1:0]  tag_d   [MSHR_COUNT][MAX_MERGE];
    logic                 we_q    [MSHR_COUNT][MAX_MERGE];
    logic                 we_d    [MSHR_COUNT][MAX_MERGE];

    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] rp_ent_q, rp_ent_d;
    logic [MP_W-1:0]  rp_pos_q, rp_pos_d;
    logic             unexp_q, unexp_d;

    logic [LINE_BITS-1:0] miss_line, fill_line;
    logic             m_hit, f_hit, free_any, rp_active, any_busy, pend_hit;
    logic [IDX_W-1:0] m_idx, f_idx, free_idx, pend_idx, scan_idx, iss_idx;
    logic             miss_fire, lc_fire, fill_fire, rp_fire;
    logic             unused_offs;

    assign miss_line   = miss_addr_in[PADDR_BITS-1:OFF_BITS];
    assign fill_line   = fill_addr_in[PADDR_BITS-1:OFF_BITS];
    assign unused_offs = ^{miss_addr_in[OFF_BITS-1:0], fill_addr_in[OFF_BITS-1:0]};

    // Descending scans so the lowest matching index wins.
    always_comb begin
        m_hit = 1'b0; m_idx = '0; f_hit = 1'b0; f_idx = '0;
        free_any = 1'b0; free_idx = '0; rp_active = 1'b0; any_busy = 1'b0;
        for (int i = MSHR_COUNT - 1; i >= 0; i--) begin
            if (state_q[i] == ST_FREE) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end else begin
                any_busy = 1'b1;
                if (line_q[i] == miss_line) begin
                    m_hit = 1'b1;
                    m_idx = IDX_W'(i);
                end
                if (state_q[i] == ST_ISSUED && line_q[i] == fill_line) begin
                    f_hit = 1'b1;
                    f_idx = IDX_W'(i);
                end
                if (state_q[i] == ST_REPLAY) rp_active = 1'b1;
            end
        end
    end

    // First PENDING entry at or after the round-robin pointer.
    always_comb begin
        pend_hit = 1'b0; pend_idx = '0; scan_idx = '0;
        for (int k = MSHR_COUNT - 1; k >= 0; k--) begin
            scan_idx = IDX_W'((int'(rr_q) + k) % MSHR_COUNT);
            if (state_q[scan_idx] == ST_PEND) begin
                pend_hit = 1'b1;
                pend_idx = scan_idx;
            end
        end
    end

    assign miss_ready_out = m_hit ? (state_q[m_idx] != ST_REPLAY && cnt_q[m_idx] != CNT_W'(MAX_MERGE))
                                  : free_any;
    assign fill_ready_out = ~rp_active;
    assign iss_idx        = lock_q ? lock_idx_q : pend_idx;
    assign lc_valid_out   = lock_q | pend_hit;
    assign lc_addr_out    = lc_valid_out ? {line_q[iss_idx], {OFF_BITS{1'b0}}} : '0;

    assign replay_valid_out = rp_active;
    assign replay_tag_out   = rp_active ? tag_q[rp_ent_q][rp_pos_q] : '0;
    assign replay_we_out    = rp_active ? we_q[rp_ent_q][rp_pos_q] : 1'b0;
    assign replay_addr_out  = rp_active ? {line_q[rp_ent_q], {OFF_BITS{1'b0}}} : '0;

    assign unexpected_fill_out = unexp_q;
    assign busy_out            = any_busy;

    assign miss_fire = miss_valid_in & miss_ready_out;
    assign lc_fire   = lc_valid_out & lc_ready_in;
    assign fill_fire = fill_valid_in & fill_ready_out;
    assign rp_fire   = replay_valid_out & replay_ready_in;

    always_comb begin
        state_d = state_q; line_d = line_q; cnt_d = cnt_q; tag_d = tag_q; we_d = we_q;
        lock_d = lock_q; lock_idx_d = lock_idx_q; rr_d = rr_q;
        rp_ent_d = rp_ent_q; rp_pos_d = rp_pos_q; unexp_d = 1'b0;

        if (miss_fire) begin
            if (m_hit) begin
                tag_d[m_idx][MP_W'(cnt_q[m_idx])] = miss_tag_in;
                we_d[m_idx][MP_W'(cnt_q[m_idx])]  = miss_we_in;
                cnt_d[m_idx] = cnt_q[m_idx] + CNT_W'(1);
            end else begin
                state_d[free_idx] = ST_PEND;
                line_d[free_idx]  = miss_line;
                cnt_d[free_idx]   = CNT_W'(1);
                tag_d[free_idx][0] = miss_tag_in;
                we_d[free_idx][0]  = miss_we_in;
            end
        end

        // The unlocked candidate is presented immediately; lock only if it stalls.
        if (lc_fire) begin
            state_d[iss_idx] = ST_ISSUED;
            rr_d   = (iss_idx == IDX_W'(MSHR_COUNT - 1)) ? '0 : iss_idx + IDX_W'(1);
            lock_d = 1'b0;
        end else if (!lock_q && pend_hit) begin
            lock_d     = 1'b1;
            lock_idx_d = pend_idx;
        end

        if (fill_fire) begin
            if (f_hit) begin
                state_d[f_idx] = ST_REPLAY;
                rp_ent_d = f_idx;
                rp_pos_d = '0;
            end else begin
                unexp_d = 1'b1;
            end
        end

        if (rp_fire) begin
            if (CNT_W'(rp_pos_q) == cnt_q[rp_ent_q] - CNT_W'(1)) begin
                state_d[rp_ent_q] = ST_FREE;
                cnt_d[rp_ent_q]   = '0;
                rp_pos_d          = '0;
            end else begin
                rp_pos_d = rp_pos_q + MP_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < MSHR_COUNT; i++) begin
                state_q[i] <= ST_FREE;
                line_q[i]  <= '0;
                cnt_q[i]   <= '0;
                for (int j = 0; j < MAX_MERGE; j++) begin
                    tag_q[i][j] <= '0;
                    we_q[i][j]  <= 1'b0;
                end
            end
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            rr_q       <= '0;
            rp_ent_q   <= '0;
            rp_pos_q   <= '0;
            unexp_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            we_q       <= we_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            rr_q       <= rr_d;
            rp_ent_q   <= rp_ent_d;
            rp_pos_q   <= rp_pos_d;
            unexp_q    <= unexp_d;
        end
    end

`ifdef MSHR_STATS_EN
    logic [31:0] st_prim_q, st_prim_d, st_merge_q, st_merge_d, st_stall_q, st_stall_d;

    always_comb begin
        st_prim_d  = st_prim_q;
        st_merge_d = st_merge_q;
        st_stall_d = st_stall_q;
        if (miss_fire && !m_hit && st_prim_q != '1)       st_prim_d  = st_prim_q + 32'd1;
        if (miss_fire && m_hit && st_merge_q != '1)       st_merge_d = st_merge_q + 32'd1;
        if (miss_valid_in && !miss_ready_out && st_stall_q != '1) st_stall_d = st_stall_q + 32'd1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            st_prim_q  <= '0;
            st_merge_q <= '0;
            st_stall_q <= '0;
        end else begin
            st_prim_q  <= st_prim_d;
            st_merge_q <= st_merge_d;
            st_stall_q <= st_stall_d;
        end
    end

    assign stat_primary_out = st_prim_q;
    assign stat_merge_out   = st_merge_q;
    assign stat_stall_out   = st_stall_q;
`endif
endmodule

// File: doc/l1d_mshr_scheduler.md
Name: l1d_mshr_scheduler

Overview:
- Miss-status controller for the L1 data cache.
- Allocates MSHRs for primary misses and merges secondary misses to the same line.
- Issues one line-fill request per MSHR to the lower cache, round-robin.
- After the fill returns, replays each merged request tag to the cache pipeline in arrival order, then frees the MSHR.

Parameters:
PADDR_BITS, 22, physical address width
B, 64, line size in bytes (power of 2); LINE_BITS = PADDR_BITS - log2(B)
MSHR_COUNT, 4, number of MSHR entries
MAX_MERGE, 4, max requests (primary + secondaries) held per entry
TAG_BITS, 10, processor request tag width

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous, active-high reset
miss_valid_in  in  1  miss request valid
miss_ready_out  out  1  miss request accepted when valid&ready
miss_addr_in  in  PADDR_BITS  miss physical address (offset bits ignored)
miss_tag_in  in  TAG_BITS  processor tag
miss_we_in  in  1  request is a store
lc_valid_out  out  1  fill request to lower cache
lc_ready_in  in  1  lower cache accepts request
lc_addr_out  out  PADDR_BITS  line-aligned address (offset bits zero)
fill_valid_in  in  1  fill returned from lower cache
fill_ready_out  out  1  fill accepted when valid&ready
fill_addr_in  in  PADDR_BITS  fill line address
replay_valid_out  out  1  replay entry valid
replay_ready_in  in  1  pipeline consumes replay
replay_tag_out  out  TAG_BITS  tag being replayed
replay_we_out  out  1  store flag of replayed request
replay_addr_out  out  PADDR_BITS  line address of replaying entry
unexpected_fill_out  out  1  one-cycle pulse: accepted fill matched no ISSUED entry
busy_out  out  1  any entry not FREE

Behaviour:
- Reset (async, rst_in=1):
  - All entries FREE, merge counts 0, round-robin pointer 0, issue lock clear.
  - Every output is 0, except fill_ready_out = 1 and miss_ready_out = 1.
- Entry states and transitions:
  - FREE -> PENDING on primary allocation.
  - PENDING -> ISSUED on lc handshake.
  - ISSUED -> REPLAY on matching fill accept.
  - REPLAY -> FREE after the last replay handshake.
  - Line match compares addr[PADDR_BITS-1:log2(B)] against every non-FREE entry.
- miss_ready_out (combinational from registered state and miss_addr_in), 0 iff:
  - the matching entry is in REPLAY; or
  - the matching entry's count == MAX_MERGE; or
  - there is no match and no FREE entry.
- Accepted miss:
  - On a match, append tag/we at index count and increment count (secondary).
  - On no match, allocate the lowest-index FREE entry with count = 1 (primary).
  - The entry is visible from the next cycle.
  - An entry freed in cycle N is allocatable from cycle N+1.
- Issue:
  - When no issue is locked, select the first PENDING entry at or after the rr pointer and lock it.
  - lc_valid_out/lc_addr_out are driven from the lock and held stable until lc_ready_in.
  - On handshake: entry becomes ISSUED, rr pointer = selected+1 mod MSHR_COUNT, lock clears.
  - Minimum latency: miss accepted at N -> lc_valid_out high at N+1.
- Fill handling:
  - fill_ready_out = 1 iff no entry is in REPLAY.
  - An accepted fill matching an ISSUED entry moves it to REPLAY, replay index 0.
  - A fill matching nothing is dropped and pulses unexpected_fill_out for one cycle.
  - A fill matching a PENDING entry is also treated as unexpected; the entry stays PENDING.
- Replay:
  - replay_valid_out is high while an entry is in REPLAY; outputs show tag[index]/we[index].
  - Each handshake increments index; the handshake at index == count-1 frees the entry.
  - Replay starts the cycle after fill accept.
- Simultaneous events:
  - A miss merging into an ISSUED entry in the same cycle its fill is accepted is merged and included in the replay.
  - Allocation, issue, fill and replay may all complete in one cycle on distinct entries.

Optional Feature:
MSHR_STATS_EN:
- Defined: adds outputs stat_primary_out[31:0], stat_merge_out[31:0], stat_stall_out[31:0].
  - Counts primary allocations, secondary merges, and cycles with miss_valid_in & !miss_ready_out.
  - Counters are saturating and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Miss 0x01040 tag 5 -> lc_valid_out next cycle with lc_addr_out=0x01040. Then fill 0x01040 -> one replay with tag 5, we=0, then busy_out=0.
- Misses 0x2000 (tag 1), 0x2008 (tag 2, store), 0x2030 (tag 3) -> a single lc request 0x2000. After fill, replays come out in order tags 1, 2 (we=1), 3.
- Five misses to distinct lines 0x000, 0x040, 0x080, 0x0C0, 0x100 with lc_ready_in=0 -> fifth sees miss_ready_out=0. lc_addr_out holds 0x000 stable; after lc_ready_in=1, requests issue in order 0x000, 0x040, 0x080, 0x0C0.
- Fifth merge to line 0x3000 with MAX_MERGE=4 -> miss_ready_out=0 until the entry is freed. The same miss is then accepted as a new primary.
- Fill 0x7FC0 with no outstanding entry -> unexpected_fill_out pulses once; no replay. Also: fill during an active replay -> fill_ready_out=0 until the replay finishes.
- Assert rst_in mid-replay (async) -> all outputs 0 immediately, except ready outputs 1. busy_out=0, and the next miss allocates entry 0.
